// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the LEGv8 fetch stage: NOP encoding,
// PC increment and the IF/ID payload carried into decode.
package if_stage_pkg;

  localparam int PKG_PC_W    = 64;
  localparam int PKG_INSTR_W = 32;

  localparam logic [PKG_INSTR_W-1:0] NOP_INSTR = 32'hD503201F;
  localparam logic [PKG_PC_W-1:0]    PC_INC    = 64'd4;

  typedef struct packed {
    logic                   valid;
    logic [PKG_PC_W-1:0]    pc;
    logic [PKG_PC_W-1:0]    pc_plus4;
    logic [PKG_INSTR_W-1:0] instr;
  } ifid_t;

  // Empty slot: what decode sees after reset or a flush.
  function automatic ifid_t ifid_bubble();
    ifid_t b;
    b.valid    = 1'b0;
    b.pc       = '0;
    b.pc_plus4 = '0;
    b.instr    = NOP_INSTR;
    return b;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: instruction-memory port, hazard/branch controls and the
// IF/ID outputs. Perf counter outputs exist only with FETCH_PERF_CNT_EN.
interface if_stage_if #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32
) ();

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               stall;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               if_id_valid;
  logic [PC_W-1:0]    if_id_pc;
  logic [PC_W-1:0]    if_id_pc_plus4;
  logic [INSTR_W-1:0] if_id_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]        perf_fetched;
  logic [31:0]        perf_stall_cycles;
`endif

  modport master (
    output imem_addr,
    input  imem_data,
    input  stall,
    input  redirect,
    input  redirect_pc,
    output if_id_valid,
    output if_id_pc,
    output if_id_pc_plus4,
`ifdef FETCH_PERF_CNT_EN
    output perf_fetched,
    output perf_stall_cycles,
`endif
    output if_id_instr
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output stall,
    output redirect,
    output redirect_pc,
    input  if_id_valid,
    input  if_id_pc,
    input  if_id_pc_plus4,
`ifdef FETCH_PERF_CNT_EN
    input  perf_fetched,
    input  perf_stall_cycles,
`endif
    input  if_id_instr
  );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise hold. Reset and
// flush both leave a NOP bubble.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic  clock,
  input  logic  reset_n,
  input  logic  load,
  input  logic  flush,
  input  ifid_t d,
  output ifid_t q
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= ifid_bubble();
    end else if (flush) begin
      q <= ifid_bubble();
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// LEGv8 instruction-fetch stage: PC register, next-PC selection and IF/ID
// capture. Define FETCH_PERF_CNT_EN to add saturating fetch/stall counters.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic      clock,
  input  logic      reset_n,
  if_stage_if.master bus
);

  logic [PC_W-1:0] pc_p0;
  logic [PC_W-1:0] pc_plus4_p0;
  logic            load_p0;
  ifid_t           ifid_d_p0;
  ifid_t           ifid_q_p1;

  // One adder feeds both the next PC and the captured pc_plus4.
  assign pc_plus4_p0 = pc_p0 + PC_W'(PC_INC);
  assign load_p0     = !bus.redirect && !bus.stall;
  assign bus.imem_addr = pc_p0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_p0 <= RESET_PC;
    end else if (bus.redirect) begin
      pc_p0 <= {bus.redirect_pc[PC_W-1:2], 2'b00};
    end else if (!bus.stall) begin
      pc_p0 <= pc_plus4_p0;
    end
  end

  always_comb begin
    ifid_d_p0          = ifid_bubble();
    ifid_d_p0.valid    = 1'b1;
    ifid_d_p0.pc       = PKG_PC_W'(pc_p0);
    ifid_d_p0.pc_plus4 = PKG_PC_W'(pc_plus4_p0);
    ifid_d_p0.instr    = PKG_INSTR_W'(bus.imem_data);
  end

  // ---- IF -> ID boundary ----
  if_id_reg u_if_id_reg (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (load_p0),
    .flush   (bus.redirect),
    .d       (ifid_d_p0),
    .q       (ifid_q_p1)
  );

  assign bus.if_id_valid    = ifid_q_p1.valid;
  assign bus.if_id_pc       = PC_W'(ifid_q_p1.pc);
  assign bus.if_id_pc_plus4 = PC_W'(ifid_q_p1.pc_plus4);
  assign bus.if_id_instr    = INSTR_W'(ifid_q_p1.instr);

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] fetched_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetched_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (load_p0) begin
        fetched_cnt <= sat_inc(fetched_cnt);
      end
      if (bus.stall && !bus.redirect) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end

  assign bus.perf_fetched      = fetched_cnt;
  assign bus.perf_stall_cycles = stall_cnt;
`endif

endmodule
